// File: rtl/pc_branch_unit.sv
// Program-counter sequencer: linear flow, NZP-conditional branches, and CALL/RET
// through a small return-address stack with sticky overflow/underflow flags.
module pc_branch_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 4,
    parameter int NZP_MODE    = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [2:0]                     core_state,
    input  logic [PC_WIDTH-1:0]            current_pc,
    input  logic [DATA_WIDTH-1:0]          alu_out,
    input  logic                           nzp_write_enable,
    input  logic                           branch_enable,
    input  logic                           call_enable,
    input  logic                           ret_enable,
    input  logic [2:0]                     decoded_nzp,
    input  logic [PC_WIDTH-1:0]            immediate,
    input  logic                           clear_errors,
    output logic [PC_WIDTH-1:0]            next_pc,
    output logic [2:0]                     nzp_flags,
    output logic                           pc_valid,
    output logic [$clog2(STACK_DEPTH):0]   stack_count,
    output logic                           stack_overflow,
    output logic                           stack_underflow
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0]          ST_EXECUTE = 3'b101;
    localparam logic [2:0]          ST_UPDATE  = 3'b110;
    localparam logic [PC_WIDTH-1:0] PC_ONE     = PC_WIDTH'(1);
    localparam logic [CW-1:0]       CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]       CNT_FULL   = CW'(STACK_DEPTH);
    localparam logic [AW-1:0]       PTR_ONE    = AW'(1);

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [PC_WIDTH-1:0] next_pc_q, next_pc_d;
    logic [2:0]          nzp_q, nzp_d, nzp_new;
    logic                pc_valid_q;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic [PC_WIDTH-1:0] pc_inc, stack_top;
    logic [AW-1:0]       wr_ptr, top_ptr;
    logic                do_exec, do_update;
    logic                stack_full, stack_empty;
    logic                take_ret, take_call, take_branch;
    logic                push, pop, branch_taken;

    assign do_exec     = enable && (core_state == ST_EXECUTE);
    assign do_update   = enable && (core_state == ST_UPDATE) && nzp_write_enable;
    assign pc_inc      = current_pc + PC_ONE;
    assign stack_full  = (count_q == CNT_FULL);
    assign stack_empty = (count_q == '0);

    // With a power-of-two depth the low count bits address the next free slot;
    // minus one wraps to the last entry when the stack is full.
    assign wr_ptr    = count_q[AW-1:0];
    assign top_ptr   = count_q[AW-1:0] - PTR_ONE;
    assign stack_top = stack_mem[top_ptr];

    assign take_ret     = do_exec && ret_enable;
    assign take_call    = do_exec && !ret_enable && call_enable;
    assign take_branch  = do_exec && !ret_enable && !call_enable && branch_enable;
    assign push         = take_call && !stack_full;
    assign pop          = take_ret && !stack_empty;
    assign branch_taken = |(decoded_nzp & nzp_q);

    generate
        if (NZP_MODE == 1) begin : g_signed_flags
            logic n_bit, z_bit;
            assign n_bit   = alu_out[DATA_WIDTH-1];
            assign z_bit   = (alu_out == '0);
            assign nzp_new = {n_bit, z_bit, !n_bit && !z_bit};
        end else begin : g_raw_flags
            logic unused_alu_bits;
            assign unused_alu_bits = ^alu_out;
            assign nzp_new         = alu_out[2:0];
        end
    endgenerate

    always_comb begin
        next_pc_d = next_pc_q;
        if (take_ret) begin
            next_pc_d = stack_empty ? pc_inc : stack_top;
        end else if (take_call) begin
            next_pc_d = stack_full ? pc_inc : immediate;
        end else if (take_branch) begin
            next_pc_d = branch_taken ? immediate : pc_inc;
        end else if (do_exec) begin
            next_pc_d = pc_inc;
        end

        count_d = count_q;
        if (push) begin
            count_d = count_q + CNT_ONE;
        end else if (pop) begin
            count_d = count_q - CNT_ONE;
        end

        nzp_d = do_update ? nzp_new : nzp_q;

        // A fresh error in the same cycle as clear_errors keeps its flag set.
        ovf_d = clear_errors ? 1'b0 : ovf_q;
        unf_d = clear_errors ? 1'b0 : unf_q;
        if (take_call && stack_full) begin
            ovf_d = 1'b1;
        end
        if (take_ret && stack_empty) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_pc_q  <= '0;
            nzp_q      <= 3'b000;
            pc_valid_q <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            next_pc_q  <= next_pc_d;
            nzp_q      <= nzp_d;
            pc_valid_q <= do_exec;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Entries are don't-care after reset; the count alone defines occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[wr_ptr] <= pc_inc;
        end
    end

    assign next_pc         = next_pc_q;
    assign nzp_flags       = nzp_q;
    assign pc_valid        = pc_valid_q;
    assign stack_count     = count_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit (signed NZP mode) with a next_pc scoreboard.
module tb_pc_branch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic [7:0] current_pc;
    logic [7:0] alu_out;
    logic       nzp_write_enable;
    logic       branch_enable;
    logic       call_enable;
    logic       ret_enable;
    logic [2:0] decoded_nzp;
    logic [7:0] immediate;
    logic       clear_errors;
    logic [7:0] next_pc;
    logic [2:0] nzp_flags;
    logic       pc_valid;
    logic [2:0] stack_count;
    logic       stack_overflow;
    logic       stack_underflow;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_pc;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_EXECUTE = 3'b101;
    localparam logic [2:0] ST_UPDATE  = 3'b110;

    pc_branch_unit #(
        .PC_WIDTH(8), .DATA_WIDTH(8), .STACK_DEPTH(4), .NZP_MODE(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .current_pc(current_pc), .alu_out(alu_out), .nzp_write_enable(nzp_write_enable),
        .branch_enable(branch_enable), .call_enable(call_enable), .ret_enable(ret_enable),
        .decoded_nzp(decoded_nzp), .immediate(immediate), .clear_errors(clear_errors),
        .next_pc(next_pc), .nzp_flags(nzp_flags), .pc_valid(pc_valid),
        .stack_count(stack_count), .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_state       = ST_IDLE;
        nzp_write_enable = 1'b0;
        branch_enable    = 1'b0;
        call_enable      = 1'b0;
        ret_enable       = 1'b0;
        clear_errors     = 1'b0;
        enable           = 1'b1;
    endtask

    // One EXECUTE cycle; the expected next_pc is queued when driven and
    // popped once the DUT signals pc_valid.
    task automatic exec(input string tag, input logic [7:0] pc, input logic call,
                        input logic ret, input logic br, input logic [2:0] nzp,
                        input logic [7:0] imm, input logic clr, input logic [7:0] expv);
        logic [7:0] popped;
        core_state    = ST_EXECUTE;
        current_pc    = pc;
        call_enable   = call;
        ret_enable    = ret;
        branch_enable = br;
        decoded_nzp   = nzp;
        immediate     = imm;
        clear_errors  = clr;
        exp_q.push_back(expv);
        tick();
        idle_inputs();
        chk({tag, ".pc_valid"}, 32'(pc_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 32'd0, 32'd1);
        end else begin
            popped = exp_q.pop_front();
            exp_pc = popped;
            chk({tag, ".next_pc"}, 32'(next_pc), 32'(popped));
        end
        $display("exec %s pc=%02h -> next_pc=%02h count=%0d ovf=%0b unf=%0b",
                 tag, pc, next_pc, stack_count, stack_overflow, stack_underflow);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        current_pc  = 8'h00;
        alu_out     = 8'h00;
        decoded_nzp = 3'b000;
        immediate   = 8'h00;
        exp_pc      = 8'h00;
        #2;
        chk("rst.next_pc", 32'(next_pc), 32'h0);
        chk("rst.nzp", 32'(nzp_flags), 32'h0);
        chk("rst.pc_valid", 32'(pc_valid), 32'h0);
        chk("rst.count", 32'(stack_count), 32'h0);
        chk("rst.ovf", 32'(stack_overflow), 32'h0);
        chk("rst.unf", 32'(stack_underflow), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Linear wrap, then pc_valid must drop and next_pc hold
        exec("wrap", 8'hFF, 0, 0, 0, 3'b000, 8'h00, 0, 8'h00);
        tick();
        chk("wrap.pulse_end", 32'(pc_valid), 32'h0);
        chk("wrap.hold", 32'(next_pc), 32'(exp_pc));

        // Flag load, then UPDATE without write enable holds flags
        core_state = ST_UPDATE; alu_out = 8'h80; nzp_write_enable = 1'b1;
        tick(); idle_inputs();
        chk("nzp.neg", 32'(nzp_flags), 32'b100);
        core_state = ST_UPDATE; alu_out = 8'h00; nzp_write_enable = 1'b0;
        tick(); idle_inputs();
        chk("nzp.hold", 32'(nzp_flags), 32'b100);

        exec("br_taken", 8'h10, 0, 0, 1, 3'b100, 8'h20, 0, 8'h20);
        exec("br_not", 8'h10, 0, 0, 1, 3'b011, 8'h20, 0, 8'h11);

        // enable=0 blocks EXECUTE and UPDATE
        enable = 1'b0; core_state = ST_EXECUTE; current_pc = 8'h55; call_enable = 1'b1;
        tick(); idle_inputs();
        chk("dis.pc_valid", 32'(pc_valid), 32'h0);
        chk("dis.next_pc", 32'(next_pc), 32'h11);
        chk("dis.count", 32'(stack_count), 32'h0);
        enable = 1'b0; core_state = ST_UPDATE; alu_out = 8'h05; nzp_write_enable = 1'b1;
        tick(); idle_inputs();
        chk("dis.nzp", 32'(nzp_flags), 32'b100);

        // Nested calls up to overflow, then unwind
        for (int i = 1; i <= 4; i++) begin
            exec("call", 8'(i), 1, 0, 0, 3'b000, 8'h40, 0, 8'h40);
        end
        chk("call.count4", 32'(stack_count), 32'd4);
        exec("call_ovf", 8'h05, 1, 0, 0, 3'b000, 8'h40, 0, 8'h06);
        chk("ovf.flag", 32'(stack_overflow), 32'd1);
        chk("ovf.count", 32'(stack_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            exec("ret", 8'h40, 0, 1, 0, 3'b000, 8'h00, 0, 8'(5 - i));
        end
        chk("ret.count0", 32'(stack_count), 32'd0);
        chk("ret.unf_clear", 32'(stack_underflow), 32'd0);

        // Underflow, clear, and clear colliding with a new underflow
        exec("ret_unf", 8'h30, 0, 1, 0, 3'b000, 8'h00, 0, 8'h31);
        chk("unf.flag", 32'(stack_underflow), 32'd1);
        chk("unf.count", 32'(stack_count), 32'd0);
        clear_errors = 1'b1;
        tick(); idle_inputs();
        chk("clr.unf", 32'(stack_underflow), 32'd0);
        chk("clr.ovf", 32'(stack_overflow), 32'd0);
        exec("clr_ret", 8'h30, 0, 1, 0, 3'b000, 8'h00, 1, 8'h31);
        chk("clr_ret.unf", 32'(stack_underflow), 32'd1);
        chk("clr_ret.ovf", 32'(stack_overflow), 32'd0);

        // RET outranks CALL and branch
        exec("call8", 8'h08, 1, 0, 0, 3'b000, 8'h40, 0, 8'h40);
        exec("prio", 8'h50, 1, 1, 1, 3'b111, 8'h77, 0, 8'h09);
        chk("prio.count", 32'(stack_count), 32'd0);

        // Asynchronous reset during a pending CALL
        exec("call20", 8'h20, 1, 0, 0, 3'b000, 8'h40, 0, 8'h40);
        core_state = ST_EXECUTE; current_pc = 8'h11; call_enable = 1'b1; immediate = 8'h66;
        #2;
        reset = 1'b1;
        #1;
        chk("arst.next_pc", 32'(next_pc), 32'h0);
        chk("arst.nzp", 32'(nzp_flags), 32'h0);
        chk("arst.pc_valid", 32'(pc_valid), 32'h0);
        chk("arst.count", 32'(stack_count), 32'h0);
        chk("arst.ovf", 32'(stack_overflow), 32'h0);
        chk("arst.unf", 32'(stack_underflow), 32'h0);
        idle_inputs();
        tick();
        chk("arst.discard", 32'(next_pc), 32'h0);
        reset = 1'b0;
        tick();
        exec("post_rst_ret", 8'h60, 0, 1, 0, 3'b000, 8'h00, 0, 8'h61);
        chk("post_rst.unf", 32'(stack_underflow), 32'd1);

        chk("sb.drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 8, meaning the program counter width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the ALU result width in bits.
REQ-003 The block SHALL have parameter STACK_DEPTH, default 4, meaning the number of return-address stack entries (power of two, >=2).
REQ-004 The block SHALL have parameter NZP_MODE, default 0: 0 loads flags from alu_out[2:0]; 1 derives flags from signed alu_out.
REQ-005 The block SHALL use one clock, clk; reset is asynchronous and active-high, named reset.
REQ-006 Ports, as name / direction / width / meaning:
 clk  in  1  clock
 reset  in  1  async active-high reset
 enable  in  1  thread active
 core_state  in  3  core FSM state; 3'b101 = EXECUTE, 3'b110 = UPDATE
 current_pc  in  PC_WIDTH  PC of the executing instruction
 alu_out  in  DATA_WIDTH  ALU result
 nzp_write_enable  in  1  CMP writeback
 branch_enable  in  1  BRnzp instruction
 call_enable  in  1  CALL instruction
 ret_enable  in  1  RET instruction
 decoded_nzp  in  3  branch condition mask {N,Z,P}
 immediate  in  PC_WIDTH  branch/call target
 clear_errors  in  1  clears sticky error flags
 next_pc  out  PC_WIDTH  registered next PC
 nzp_flags  out  3  registered {N,Z,P}
 pc_valid  out  1  one-cycle pulse: next_pc updated
 stack_count  out  clog2(STACK_DEPTH)+1  occupied stack entries
 stack_overflow  out  1  sticky: CALL attempted with stack full
 stack_underflow  out  1  sticky: RET attempted with stack empty

Function
REQ-007 On UPDATE with nzp_write_enable=1 and enable=1, nzp_flags SHALL load on that clock edge; otherwise nzp_flags SHALL hold.
REQ-008 NZP_MODE=0: nzp_flags SHALL equal alu_out[2:0].
REQ-009 NZP_MODE=1: N SHALL equal alu_out[DATA_WIDTH-1]; Z SHALL be 1 iff alu_out==0; P SHALL be 1 iff neither N nor Z; exactly one flag set.
REQ-010 next_pc SHALL update only on EXECUTE with enable=1, one edge after the inputs are sampled, with pc_valid=1 for exactly that following cycle; otherwise next_pc SHALL hold and pc_valid SHALL be 0.
REQ-011 EXECUTE priority SHALL be ret_enable > call_enable > branch_enable > linear; lower-priority enables are ignored.
REQ-012 Linear flow: next_pc SHALL equal current_pc+1 modulo 2^PC_WIDTH (all-ones wraps to 0).
REQ-013 Branch: taken iff (decoded_nzp & nzp_flags) != 0, using flags registered before this edge; taken -> immediate, not taken -> current_pc+1.
REQ-014 CALL, stack not full: push current_pc+1 (wrapped), next_pc = immediate, stack_count +1.
REQ-015 CALL, stack full (stack_count==STACK_DEPTH): no push, stack contents unchanged, next_pc = current_pc+1, stack_overflow set.
REQ-016 RET, stack not empty: next_pc = top entry, pop, stack_count -1 (LIFO).
REQ-017 RET, stack empty: next_pc = current_pc+1, stack_count stays 0, stack_underflow set.
REQ-018 clear_errors=1 SHALL clear both sticky flags on the next edge; a new error event in the same cycle SHALL win (flag remains set).
REQ-019 enable=0 SHALL suppress all state changes except clear_errors.

Reset
REQ-020 While reset is high, asynchronously and regardless of clk: next_pc=0, nzp_flags=3'b000, pc_valid=0, stack_count=0, stack_overflow=0, stack_underflow=0; stack entries are don't-care.
REQ-021 Reset asserted mid-EXECUTE SHALL discard the pending update; the first post-reset EXECUTE behaves as with an empty stack.

Verification
REQ-022 Linear wrap: current_pc=8'hFF, EXECUTE, no control enables -> next_pc=8'h00, pc_valid pulses once.
REQ-023 Branch: NZP_MODE=1, UPDATE alu_out=8'h80 -> nzp_flags=3'b100; EXECUTE BRn (decoded_nzp=3'b100), immediate=8'h20 -> next_pc=8'h20; same with decoded_nzp=3'b011, current_pc=8'h10 -> next_pc=8'h11.
REQ-024 Nested calls: CALL at pc 1,2,3,4 (immediate 8'h40) -> stack_count=4; fifth CALL at pc 5 -> next_pc=8'h06, stack_overflow=1; four RETs -> next_pc 5,4,3,2 in order.
REQ-025 Underflow/clear: RET with empty stack at pc 8'h30 -> next_pc=8'h31, stack_underflow=1; clear_errors -> 0 next cycle; clear_errors plus RET on empty -> stays 1.
REQ-026 Priority and reset: call_enable, ret_enable, branch_enable all 1 with stack_count=1 (top 8'h09) -> next_pc=8'h09; assert reset asynchronously mid-cycle -> all outputs reach reset values before the next clk edge.
